// File: rtl/dmem_pkg.sv
// Shared encodings for the two-port data-memory arbiter.
package dmem_pkg;

  localparam int MEM_WORDS = 64;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef logic [1:0] dmem_state_t;

  localparam dmem_state_t ST_IDLE   = 2'd0;
  localparam dmem_state_t ST_ACCESS = 2'd1;
  localparam dmem_state_t ST_WRITE  = 2'd2;
  localparam dmem_state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/dmem_lane_merge.sv
// Lane insert for read-modify-write stores and zero-extended lane extract for loads.
module dmem_lane_merge
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            byte_off,
  input  logic [1:0]            size,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] load
);

  localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(16'h00FF);
  localparam logic [DATA_WIDTH-1:0] HALF_MASK = DATA_WIDTH'(16'hFFFF);

  logic [4:0] sh_b;
  logic [4:0] sh_h;

  assign sh_b = {byte_off, 3'b000};
  assign sh_h = {byte_off[1], 4'b0000};

  always_comb begin
    merged = old_word;
    load   = '0;
    case (size)
      SZ_BYTE: begin
        merged = (old_word & ~(BYTE_MASK << sh_b)) | ((wdata & BYTE_MASK) << sh_b);
        load   = (old_word >> sh_b) & BYTE_MASK;
      end
      SZ_HALF: begin
        merged = (old_word & ~(HALF_MASK << sh_h)) | ((wdata & HALF_MASK) << sh_h);
        load   = (old_word >> sh_h) & HALF_MASK;
      end
      SZ_WORD: begin
        merged = wdata;
        load   = old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the word-only data memory;
// byte and halfword stores are carried out as read-modify-write.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [1:0]            size0,
  input  logic [1:0]            size1,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  // state  | meaning
  // IDLE   | arbitrate; latch the winner's request
  // ACCESS | address memory, capture read word; word stores write here
  // WRITE  | write the merged word of a byte/half store
  // RESP   | done, err and rdata presented for one cycle

  dmem_state_t           state_q;
  logic                  port_q;
  logic                  we_q;
  logic                  last_grant_q;
  logic                  win;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] lane_src;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] load;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            size_q;
  logic [1:0]            done_q;
  logic                  err_q;
  logic                  acc_err;
  logic                  word_store;

  // On a tie the port that lost last time wins.
  always_comb begin
    win = 1'b0;
    gnt = 2'b00;
    if (!reset && state_q == ST_IDLE && |req) begin
      win = (req == 2'b11) ? ~last_grant_q : req[1];
      gnt = win ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    case (size_q)
      SZ_HALF: acc_err = addr_q[0];
      SZ_WORD: acc_err = |addr_q[1:0];
      SZ_BAD:  acc_err = 1'b1;
      default: acc_err = 1'b0;
    endcase
  end

  assign word_store = we_q && !acc_err && (size_q == SZ_WORD);
  assign lane_src   = (state_q == ST_WRITE) ? word_q : mem_rd_data;

  dmem_lane_merge #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .old_word (lane_src),
    .wdata    (wdata_q),
    .byte_off (addr_q[1:0]),
    .size     (size_q),
    .merged   (merged),
    .load     (load)
  );

  // Write strobe is masked by reset so an interrupted RMW never reaches memory.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    if (!reset) begin
      if (state_q == ST_ACCESS && word_store) begin
        mem_wr_en   = 1'b1;
        mem_wr_data = wdata_q;
      end else if (state_q == ST_WRITE) begin
        mem_wr_en   = 1'b1;
        mem_wr_data = merged;
      end
    end
  end

  assign mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= SZ_BYTE;
      word_q       <= '0;
      done_q       <= 2'b00;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            port_q       <= win;
            last_grant_q <= win;
            we_q         <= we[win];
            addr_q       <= win ? addr1 : addr0;
            wdata_q      <= win ? wdata1 : wdata0;
            size_q       <= win ? size1 : size0;
            state_q      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          word_q <= mem_rd_data;
          if (we_q && !acc_err && size_q != SZ_WORD) begin
            state_q <= ST_WRITE;
          end else begin
            state_q <= ST_RESP;
            done_q  <= {port_q, ~port_q};
            err_q   <= acc_err;
            rdata_q <= (we_q || acc_err) ? '0 : load;
          end
        end
        ST_WRITE: begin
          state_q <= ST_RESP;
          done_q  <= {port_q, ~port_q};
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, tie/reset sequences and random accesses
// checked against a byte-addressed memory model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic [1:0]  gnt, done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_wr_en;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

  logic [31:0] mem [MEM_WORDS];
  logic [7:0]  ref_b [4*MEM_WORDS];
  logic        load_en;
  logic        last_win;
  int          vectors;
  int          miscompares;

  typedef struct {
    int          port;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        exp_err;
    int          exp_done;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .size0(size0), .size1(size1), .gnt(gnt), .done(done), .err(err),
    .rdata(rdata), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input int i);
    return {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
  endfunction

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= ref_word(i);
    end else if (mem_wr_en) begin
      mem[mem_addr[7:2]] <= mem_wr_data;
    end
  end
  assign mem_rd_data = mem[mem_addr[7:2]];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
  endfunction

  function automatic logic bad_access(input logic [31:0] a, input logic [1:0] sz);
    if (sz == SZ_BAD) return 1'b1;
    return (int'(a[7:0]) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nbytes(sz); i++) v = v | (32'(ref_b[int'(a[7:0]) + i]) << (8*i));
    return v;
  endfunction

  function automatic void store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    for (int i = 0; i < nbytes(sz); i++) ref_b[int'(a[7:0]) + i] = 8'(d >> (8*i));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, ".gnt"}, 32'(gnt), 0);
    chk({nm, ".done"}, 32'(done), 0);
    chk({nm, ".err"}, 32'(err), 0);
    chk({nm, ".wr_en"}, 32'(mem_wr_en), 0);
    chk({nm, ".rdata"}, rdata, 0);
    chk({nm, ".mem_addr"}, mem_addr, 0);
    chk({nm, ".mem_wr_data"}, mem_wr_data, 0);
  endtask

  // One request on one port; entered and left just after a rising edge with the DUT idle.
  task automatic exec(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, output logic [31:0] rd, output logic e,
                      output int gat, output int dat, output int wcnt, output int wat,
                      output logic [31:0] wd);
    gat = -1; dat = -1; wcnt = 0; wat = -1; wd = '0; rd = '0; e = 1'b0;
    we[p] = w;
    if (p == 0) begin addr0 = a; wdata0 = d; size0 = sz; end
    else begin addr1 = a; wdata1 = d; size1 = sz; end
    req[p] = 1'b1;
    for (int k = 0; k < 8 && dat < 0; k++) begin
      @(negedge clk);
      if (gnt[p] && gat < 0) gat = k;
      if (mem_wr_en) begin wcnt++; wat = k; wd = mem_wr_data; end
      if (done[p]) begin dat = k; rd = rdata; e = err; end
      @(posedge clk); #1;
    end
    req[p] = 1'b0;
  endtask

  task automatic run(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input string nm, output logic [31:0] rd,
                     output logic e, output logic [31:0] wd, output int dat);
    logic        x_e;
    logic [31:0] x_rd, x_wd;
    int          x_nwr, x_wat, x_dat, gat, wcnt, wat;
    x_e   = bad_access(a, sz);
    x_rd  = (!w && !x_e) ? load_val(a, sz) : 32'h0;
    x_nwr = 0; x_wd = '0; x_wat = -1; x_dat = 2;
    if (w && !x_e) begin
      store(a, d, sz);
      x_nwr = 1;
      x_wd  = ref_word(int'(a[7:2]));
      x_wat = (sz == SZ_WORD) ? 1 : 2;
      x_dat = (sz == SZ_WORD) ? 2 : 3;
    end
    exec(p, w, a, d, sz, rd, e, gat, dat, wcnt, wat, wd);
    chk({nm, ".gnt_at"}, gat, 0);
    chk({nm, ".done_at"}, dat, x_dat);
    chk({nm, ".err"}, 32'(e), 32'(x_e));
    if (!w || x_e) chk({nm, ".rdata"}, rd, x_rd);
    chk({nm, ".writes"}, wcnt, x_nwr);
    if (x_nwr != 0) begin
      chk({nm, ".wr_data"}, wd, x_wd);
      chk({nm, ".wr_at"}, wat, x_wat);
    end
    last_win = p[0];
  endtask

  // Both ports issue word reads in the same cycle.
  task automatic tie(input logic [31:0] a0, input logic [31:0] a1, input string nm);
    int          first, second;
    int          gat[2], gcnt[2], dat[2], dcnt[2];
    logic [31:0] rd[2], aa[2];
    first  = last_win ? 0 : 1;
    second = 1 - first;
    aa[0] = a0; aa[1] = a1;
    for (int q = 0; q < 2; q++) begin
      gat[q] = -1; gcnt[q] = 0; dat[q] = -1; dcnt[q] = 0; rd[q] = '0;
    end
    addr0 = a0; addr1 = a1; size0 = SZ_WORD; size1 = SZ_WORD; we = 2'b00; req = 2'b11;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        if (gnt[q]) begin gcnt[q]++; if (gat[q] < 0) gat[q] = k; end
        if (done[q]) begin dcnt[q]++; dat[q] = k; rd[q] = rdata; end
      end
      @(posedge clk); #1;
      for (int q = 0; q < 2; q++) if (dcnt[q] > 0) req[q] = 1'b0;
    end
    req = 2'b00;
    chk({nm, ".first_gnt_at"}, gat[first], 0);
    chk({nm, ".second_gnt_at"}, gat[second], 3);
    chk({nm, ".first_done_at"}, dat[first], 2);
    chk({nm, ".second_done_at"}, dat[second], 5);
    for (int q = 0; q < 2; q++) begin
      chk($sformatf("%s.gnt_count%0d", nm, q), gcnt[q], 1);
      chk($sformatf("%s.done_count%0d", nm, q), dcnt[q], 1);
      chk($sformatf("%s.rdata%0d", nm, q), rd[q], load_val(aa[q], SZ_WORD));
    end
    last_win = second[0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd, a, d;
    logic        e, w;
    logic [1:0]  sz;
    int          dat, p;

    vectors = 0; miscompares = 0; last_win = 1'b1;
    reset = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; size0 = SZ_BYTE; size1 = SZ_BYTE;
    for (int i = 0; i < 4*MEM_WORDS; i++) ref_b[i] = 8'h00;
    ref_b[0] = 8'h44; ref_b[1] = 8'h33; ref_b[2] = 8'h22; ref_b[3] = 8'h11;
    ref_b[4] = 8'h07;
    load_en = 1'b1;

    tbl[0]  = '{0, 1'b0, 32'h4, 32'h0,        SZ_WORD, 1'b0, 2, 32'h0000_0007};
    tbl[1]  = '{1, 1'b1, 32'h5, 32'hAB,       SZ_BYTE, 1'b0, 3, 32'h0000_AB07};
    tbl[2]  = '{0, 1'b0, 32'h4, 32'h0,        SZ_WORD, 1'b0, 2, 32'h0000_AB07};
    tbl[3]  = '{0, 1'b1, 32'h3, 32'hBEEF,     SZ_HALF, 1'b1, 2, 32'h0};
    tbl[4]  = '{0, 1'b0, 32'h0, 32'h0,        SZ_WORD, 1'b0, 2, 32'h1122_3344};
    tbl[5]  = '{0, 1'b1, 32'h8, 32'hDEADBEEF, SZ_WORD, 1'b0, 2, 32'hDEAD_BEEF};
    tbl[6]  = '{0, 1'b0, 32'hA, 32'h0,        SZ_HALF, 1'b0, 2, 32'h0000_DEAD};
    tbl[7]  = '{1, 1'b0, 32'hB, 32'h0,        SZ_BYTE, 1'b0, 2, 32'h0000_00DE};
    tbl[8]  = '{1, 1'b0, 32'h8, 32'h0,        SZ_BAD,  1'b1, 2, 32'h0};
    tbl[9]  = '{1, 1'b0, 32'h6, 32'h0,        SZ_WORD, 1'b1, 2, 32'h0};
    tbl[10] = '{1, 1'b1, 32'h2, 32'hFFFF1234, SZ_HALF, 1'b0, 3, 32'h1234_3344};
    tbl[11] = '{0, 1'b1, 32'h8, 32'h5A,       SZ_BYTE, 1'b0, 3, 32'hDEAD_BE5A};
    tbl[12] = '{0, 1'b0, 32'h1, 32'h0,        SZ_BYTE, 1'b0, 2, 32'h0000_0033};

    repeat (2) @(posedge clk);
    #1 load_en = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    tie(32'h4, 32'h0, "tie_after_reset");

    for (int i = 0; i < 13; i++) begin
      run(tbl[i].port, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].sz, $sformatf("vec%0d", i), rd, e, wd, dat);
      chk($sformatf("vec%0d.tbl_err", i), 32'(e), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d.tbl_done_at", i), dat, tbl[i].exp_done);
      if (tbl[i].w && !tbl[i].exp_err) chk($sformatf("vec%0d.tbl_wr_data", i), wd, tbl[i].exp);
      else chk($sformatf("vec%0d.tbl_rdata", i), rd, tbl[i].exp);
    end

    tie(32'h8, 32'h4, "tie_rr");

    // Byte store interrupted by reset in its WRITE cycle.
    we[1] = 1'b1; addr1 = 32'h10; wdata1 = 32'h77; size1 = SZ_BYTE; req[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_write.wr_en", 32'(mem_wr_en), 0);
    chk("rst_write.done", 32'(done), 0);
    @(posedge clk); #1;
    reset = 1'b0; req = 2'b00;
    @(negedge clk);
    chk_quiet("after_rst");
    chk("rst_write.mem", mem[4], ref_word(4));
    last_win = 1'b1;
    @(posedge clk); #1;
    tie(32'hC, 32'h10, "tie_after_midop_reset");
    run(1, 1'b1, 32'h11, 32'h66, SZ_BYTE, "fresh_after_reset", rd, e, wd, dat);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        tie(32'($urandom_range(0, 63)) << 2, 32'($urandom_range(0, 63)) << 2, $sformatf("rnd_tie%0d", t));
      end else begin
        p  = int'($urandom_range(0, 1));
        w  = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3));
        a  = 32'($urandom_range(0, 255));
        d  = $urandom();
        if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
        run(p, w, a, d, sz, $sformatf("rnd%0d", t), rd, e, wd, dat);
      end
    end

    for (int i = 0; i < MEM_WORDS; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_word(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the word-only data memory (64 × 32-bit, combinational read, synchronous write). It lets the CPU load/store path (port 0) and a debug/DMA port (port 1) share that memory under round-robin arbitration. It also implements byte and halfword stores as read-modify-write sequences, because the memory only supports full-word writes. It sits between the requesters and the data memory instance; the memory itself is unchanged.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, byte address width
- `clk` input 1, sole clock; all state updates on the rising edge
- `reset` input 1, synchronous, active-high
- `req[1:0]` input 2, per-port request; held until that port's `done`
- `we[1:0]` input 2, per-port write (1) / read (0)
- `addr0`, `addr1` input ADDR_WIDTH, per-port byte address
- `wdata0`, `wdata1` input DATA_WIDTH, per-port store data; the value sits in the low bits for byte/half accesses
- `size0`, `size1` input 2, per-port access size: 00 byte, 01 half, 10 word, 11 illegal
- `gnt[1:0]` output 2, one-hot grant pulse in the acceptance cycle
- `done[1:0]` output 2, one-hot completion pulse, registered
- `err` output 1, valid with `done`; 1 = misaligned or illegal size
- `rdata` output DATA_WIDTH, load result (zero-extended), valid with `done`
- `mem_wr_en` output 1, memory write enable
- `mem_addr` output ADDR_WIDTH, word-aligned address (`addr & ~3`)
- `mem_wr_data` output DATA_WIDTH, memory write data
- `mem_rd_data` input DATA_WIDTH, memory combinational read data

## Operation
- FSM states:
  - IDLE: arbitrate; on a grant, latch port, we, addr, wdata and size, then go to ACCESS.
  - ACCESS: drive `mem_addr` and capture `mem_rd_data`.
    - Reads, word writes and errors go to RESP.
    - Sub-word writes go to WRITE.
  - WRITE: drive the merged word with `mem_wr_en=1`, then go to RESP.
  - RESP: pulse `done`, then go to IDLE.
- Arbitration:
  - Single request: that port wins.
  - Both requesting: the port that did not win last time wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - `gnt` is combinational, asserted only in IDLE.
- Alignment:
  - A half access needs `addr[0]=0`; a word access needs `addr[1:0]=0`.
  - Size 11 is always an error.
  - An error access makes no memory write, returns `rdata=0` and sets `err=1`.
- Word write: `mem_wr_en=1` in ACCESS with `mem_wr_data=wdata`.
- Sub-word write (RMW):
  - In ACCESS, register `mem_rd_data`.
  - Replace byte lane `addr[1:0]` (byte) or halfword lane `addr[1]` (half) with the low bits of `wdata`.
  - Write the merged word in WRITE.
- Read:
  - `rdata` is the selected lane of the word captured in ACCESS, zero-extended.
  - Sign extension belongs to the requester.
- `mem_wr_en` is 0 in every state except as specified above.
- Requests from the non-granted port are ignored until the FSM returns to IDLE.

## Timing
- Request first seen in IDLE at cycle N: `gnt` pulses in N, ACCESS occupies N+1.
- `done` (and `rdata`/`err`) registered:
  - read, word write and error: `done` at N+2.
  - sub-word write: WRITE at N+2, `done` at N+3.
- RESP→IDLE: the next grant occurs at N+3 (or N+4 for a sub-word write). Peak throughput is one access per 3 cycles.
- Reset values:
  - state IDLE, `last_grant`=1.
  - `gnt`, `done`, `err` and `mem_wr_en` all 0.
  - `rdata` 0; `mem_addr` and `mem_wr_data` 0.
- Reset mid-operation:
  - Abandon the sequence; no `done` is issued.
  - A WRITE cycle coincident with `reset` does not assert `mem_wr_en`.
- `req` dropped after grant: the access still completes. Requesters must not do this.
- `req` and `done` in the same cycle for the same port: `done` completes the transaction. A new request is sampled only in IDLE.

## Structure
- Shared package `dmem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`
  - FSM state enum
  - `MEM_WORDS=64`
- One sub-module, `dmem_lane_merge`, purely combinational:
  - (old word, wdata, addr[1:0], size) → merged word
  - (word, addr[1:0], size) → extracted zero-extended load

## Test plan
- Memory preloaded with word1=0x00000007. Port 0 reads word, addr 0x4 → `gnt[0]` at N, `done[0]` at N+2, `rdata=0x00000007`, `err=0`.
- Port 1 stores byte 0xAB to 0x5 over word1=0x00000007 → `mem_wr_en` only at N+2 with `mem_wr_data=0x0000AB07`, `done[1]` at N+3.
- Both ports request reads at the same cycle after reset → port 0 granted first, port 1 granted at N+3, each `done` exactly once.
- Port 0 stores half to 0x3 → no `mem_wr_en` pulse, `done[0]` with `err=1`, `rdata=0`; memory unchanged.
- Port 0 stores word 0xDEADBEEF to 0x8, then reads half at 0xA → `rdata=0x0000DEAD`.
- Assert `reset` in the WRITE cycle of a sub-word store → no memory write, no `done`, all outputs 0 next cycle, a fresh request is accepted normally.
